// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 serial receiver with a registered byte and a sticky rdy/clr_rdy handshake.
// Defining UART_RX_FRAME_ERR_EN adds the frame_err output (stop bit sampled low).
module uart_rx_byte #(
    parameter int unsigned BAUD_DIV = 5208
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy
`ifdef UART_RX_FRAME_ERR_EN
    ,
    output logic       frame_err
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECEIVE = 2'd1
    } state_t;

    // baud_cnt holds the clocks remaining up to and including the sample clock,
    // so a load of N samples N clocks later and a reload of BAUD_DIV gives one bit period.
    localparam logic [15:0] HALF_CNT = 16'(BAUD_DIV / 2);
    localparam logic [15:0] FULL_CNT = 16'(BAUD_DIV);

    state_t      state, state_nxt;
    logic        rx_meta, rx_s, rx_prev;
    logic [15:0] baud_cnt, baud_nxt;
    logic [3:0]  bit_cnt, bit_nxt;
    logic [8:0]  shifter, shift_nxt;
    logic [7:0]  data_nxt;
    logic        rdy_nxt;
`ifdef UART_RX_FRAME_ERR_EN
    logic        ferr_nxt;
`endif

    // Sync chain presets high so reset can never look like a falling start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= 16'd0;
            bit_cnt  <= 4'd0;
            shifter  <= 9'd0;
            rx_data  <= 8'h00;
            rdy      <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
            frame_err <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_cnt  <= bit_nxt;
            shifter  <= shift_nxt;
            rx_data  <= data_nxt;
            rdy      <= rdy_nxt;
`ifdef UART_RX_FRAME_ERR_EN
            frame_err <= ferr_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_cnt;
        shift_nxt = shifter;
        data_nxt  = rx_data;
        rdy_nxt   = rdy;
`ifdef UART_RX_FRAME_ERR_EN
        ferr_nxt  = frame_err;
`endif

        // Clear first; a frame completing in the same cycle overrides it below.
        if (clr_rdy) begin
            rdy_nxt = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
            ferr_nxt = 1'b0;
`endif
        end

        case (state)
            IDLE: begin
                if (rx_prev && !rx_s) begin
                    state_nxt = RECEIVE;
                    baud_nxt  = HALF_CNT;
                    bit_nxt   = 4'd0;
                    rdy_nxt   = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
                    ferr_nxt  = 1'b0;
`endif
                end
            end
            RECEIVE: begin
                if (baud_cnt == 16'd1) begin
                    shift_nxt = {rx_s, shifter[8:1]};
                    baud_nxt  = FULL_CNT;
                    bit_nxt   = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd0 && rx_s) begin
                        state_nxt = IDLE;
                    end else if (bit_cnt == 4'd9) begin
                        // shifter holds start..bit7; the data byte is its top eight bits
                        state_nxt = IDLE;
                        data_nxt  = shifter[8:1];
                        rdy_nxt   = 1'b1;
`ifdef UART_RX_FRAME_ERR_EN
                        ferr_nxt  = ~rx_s;
`endif
                    end
                end else begin
                    baud_nxt = baud_cnt - 16'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte at 16 clk/bit: expected bytes go to a scoreboard queue,
// a monitor pops them on each rdy rise and also evaluates queued point checks.
module tb_uart_rx_byte;

    localparam int BAUD = 16;

    logic       clk;
    logic       rst_n;
    logic       RX;
    logic       clr_rdy;
    logic [7:0] rx_data;
    logic       rdy;
`ifdef UART_RX_FRAME_ERR_EN
    logic       frame_err;
`endif

    uart_rx_byte #(.BAUD_DIV(BAUD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .RX        (RX),
        .clr_rdy   (clr_rdy),
        .rx_data   (rx_data),
        .rdy       (rdy)
`ifdef UART_RX_FRAME_ERR_EN
        ,
        .frame_err (frame_err)
`endif
    );

    typedef struct {
        logic [7:0] data;
        logic       ferr;
    } exp_t;

    typedef struct {
        string name;
        int    got;
        int    lo;
        int    hi;
    } chk_t;

    exp_t exp_q[$];
    chk_t chk_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;
    int   fall_cyc = 0;
    int   rise_cyc = 0;
    logic saw_low;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not reach the end, got %0d cycles required fewer", cyc);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input int got, input int lo, input int hi);
        chk_q.push_back('{name, got, lo, hi});
    endtask

    task automatic expect_byte(input logic [7:0] d, input logic fe);
        exp_q.push_back('{d, fe});
    endtask

    // Drives one frame starting at a negedge; drops a held clr_rdy as soon as rdy is seen.
    task automatic send_frame(input logic [7:0] d, input logic stop, output logic low_seen);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        low_seen = 1'b0;
        fall_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            RX = bits[i];
            repeat (BAUD) begin
                @(negedge clk);
                if (!rdy) low_seen = 1'b1;
                if (clr_rdy && rdy) clr_rdy = 1'b0;
            end
        end
    endtask

    task automatic pulse_clr();
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
    endtask

    // Monitor / scoreboard
    initial begin
        logic rdy_q;
        exp_t e;
        chk_t c;
        rdy_q = 1'b0;
        forever begin
            @(negedge clk);
            if (rdy && !rdy_q) begin
                rise_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_byte: got %02h required no frame", rx_data);
                end else begin
                    e = exp_q.pop_front();
                    n_total++;
                    if (rx_data === e.data) n_pass++;
                    else $display("FAIL rx_byte: got %02h required %02h", rx_data, e.data);
`ifdef UART_RX_FRAME_ERR_EN
                    n_total++;
                    if (frame_err === e.ferr) n_pass++;
                    else $display("FAIL frame_err_at_rdy: got %0b required %0b", frame_err, e.ferr);
`endif
                end
            end
            rdy_q = rdy;
            while (chk_q.size() > 0) begin
                c = chk_q.pop_front();
                n_total++;
                if (c.got >= c.lo && c.got <= c.hi) n_pass++;
                else $display("FAIL %s: got %0d required %0d..%0d", c.name, c.got, c.lo, c.hi);
            end
        end
    end

    // Stimulus
    initial begin
        rst_n   = 1'b0;
        RX      = 1'b1;
        clr_rdy = 1'b0;
        repeat (5) @(negedge clk);
        chk("reset_rdy", int'(rdy), 0, 0);
        chk("reset_data", int'(rx_data), 0, 0);
`ifdef UART_RX_FRAME_ERR_EN
        chk("reset_frame_err", int'(frame_err), 0, 0);
`endif
        rst_n = 1'b1;
        repeat (500) @(negedge clk);
        chk("idle_rdy", int'(rdy), 0, 0);
        chk("idle_data", int'(rx_data), 0, 0);

        // 0xA5: latency, data, clr_rdy
        expect_byte(8'hA5, 1'b0);
        send_frame(8'hA5, 1'b1, saw_low);
        chk("latency", rise_cyc - fall_cyc, 153, 155);
        chk("a5_rdy", int'(rdy), 1, 1);
        chk("a5_data", int'(rx_data), 'hA5, 'hA5);
        pulse_clr();
        chk("clr_rdy_clears", int'(rdy), 0, 0);
        chk("clr_keeps_data", int'(rx_data), 'hA5, 'hA5);

        // Back-to-back 0x3C, 0xC3 with no clr_rdy
        expect_byte(8'h3C, 1'b0);
        expect_byte(8'hC3, 1'b0);
        send_frame(8'h3C, 1'b1, saw_low);
        chk("b2b_first_rdy", int'(rdy), 1, 1);
        send_frame(8'hC3, 1'b1, saw_low);
        chk("b2b_rdy_dropped", int'(saw_low), 1, 1);
        chk("b2b_rdy", int'(rdy), 1, 1);
        chk("b2b_data", int'(rx_data), 'hC3, 'hC3);

        // 4-clk glitch is a false start
        pulse_clr();
        RX = 1'b0;
        repeat (4) @(negedge clk);
        RX = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_rdy", int'(rdy), 0, 0);
        chk("glitch_data", int'(rx_data), 'hC3, 'hC3);
        expect_byte(8'h5A, 1'b0);
        send_frame(8'h5A, 1'b1, saw_low);
        chk("after_glitch_data", int'(rx_data), 'h5A, 'h5A);
        pulse_clr();

        // Reset during bit 4 of 0xFF
        RX = 1'b0;
        repeat (BAUD) @(negedge clk);
        RX = 1'b1;
        repeat (BAUD * 4 + 8) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("midreset_rdy", int'(rdy), 0, 0);
        chk("midreset_data", int'(rx_data), 0, 0);
        rst_n = 1'b1;
        repeat (BAUD * 8) @(negedge clk);
        chk("no_partial_rdy", int'(rdy), 0, 0);
        expect_byte(8'h01, 1'b0);
        send_frame(8'h01, 1'b1, saw_low);
        chk("post_reset_rdy", int'(rdy), 1, 1);
        chk("post_reset_data", int'(rx_data), 'h01, 'h01);
        pulse_clr();

        // 0x77 with a zero stop bit
        expect_byte(8'h77, 1'b1);
        send_frame(8'h77, 1'b0, saw_low);
        RX = 1'b1;
        chk("bad_stop_rdy", int'(rdy), 1, 1);
        chk("bad_stop_data", int'(rx_data), 'h77, 'h77);
        pulse_clr();
        chk("bad_stop_clr_rdy", int'(rdy), 0, 0);
`ifdef UART_RX_FRAME_ERR_EN
        chk("bad_stop_clr_ferr", int'(frame_err), 0, 0);
`endif
        repeat (BAUD) @(negedge clk);

        // Break: exactly one all-zero frame
        expect_byte(8'h00, 1'b1);
        RX = 1'b0;
        repeat (400) @(negedge clk);
        chk("break_rdy", int'(rdy), 1, 1);
        chk("break_data", int'(rx_data), 0, 0);
        pulse_clr();
        RX = 1'b1;
        repeat (BAUD * 2) @(negedge clk);

        // clr_rdy held across frame completion: set wins
        expect_byte(8'h96, 1'b0);
        clr_rdy = 1'b1;
        send_frame(8'h96, 1'b1, saw_low);
        clr_rdy = 1'b0;
        chk("collision_rdy", int'(rdy), 1, 1);
        chk("collision_data", int'(rx_data), 'h96, 'h96);

        repeat (20) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0, 0);
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
